stoch_chan_src: RTL and testbench

STOCH_CHAN_SRC -- requirements
Module: stoch_chan_src

---
 rtl/stoch_chan_src.sv | 131 +++++++++++++
 tb/tb_stoch_chan_src.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/stoch_chan_src.sv
// rtl/stoch_chan_src.sv - stochastic channel-bit source with LFSR select for an equality node; define SRC_SEED_PORT_EN to add the SEED_IN reseed port
module stoch_chan_src #(
   parameter int                LFSR_S   = 8,
   parameter int                PROB_W   = 8,
   parameter int                INIT_CYC = 16,
   parameter int                MAX_CYC  = 1024,
   parameter logic [LFSR_S-1:0] SEED     = LFSR_S'(8'h01)
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              LD_VLD,
   output logic              LD_RDY,
   input  logic [PROB_W-1:0] P,
   input  logic              STOP,
`ifdef SRC_SEED_PORT_EN
   input  logic [LFSR_S-1:0] SEED_IN,
`endif
   output logic              C,
   output logic [LFSR_S-1:0] SEL,
   output logic              INIT,
   output logic              BUSY,
   output logic              DONE
);

   // One counter serves both phases, so it must hold the longer of the two.
   localparam int MAXC = (INIT_CYC > MAX_CYC) ? INIT_CYC : MAX_CYC;
   localparam int CW   = $clog2(MAXC + 1);
   localparam logic [CW-1:0] INIT_LAST = CW'(INIT_CYC - 1);
   localparam logic [CW-1:0] RUN_LAST  = CW'(MAX_CYC - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_INITS = 2'd1,
      S_RUN   = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [LFSR_S-1:0]   lfsr_q, lfsr_d;
   logic [PROB_W-1:0]   preg_q, preg_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [LFSR_S-1:0]   lfsr_step;
   logic [LFSR_S-1:0]   seed_src;
   logic                fb;
   logic                busy;
   logic                load;

   // An all-zero LFSR never leaves zero, so a zero seed is promoted to 1.
   function automatic logic [LFSR_S-1:0] fix_seed(input logic [LFSR_S-1:0] s);
      return (s == '0) ? LFSR_S'(1) : s;
   endfunction

`ifdef SRC_SEED_PORT_EN
   assign seed_src = SEED_IN;
`else
   assign seed_src = SEED;
`endif

   generate
      if (LFSR_S == 16) begin : g_tap16
         assign fb = lfsr_q[15] ^ lfsr_q[14] ^ lfsr_q[12] ^ lfsr_q[3];
      end else begin : g_tap8
         assign fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
      end
   endgenerate

   assign lfsr_step = {lfsr_q[LFSR_S-2:0], fb};

   assign busy   = (state_q == S_INITS) || (state_q == S_RUN);
   assign LD_RDY = (state_q == S_IDLE)  || (state_q == S_DONE);
   assign load   = LD_VLD && LD_RDY;

   // Next-state logic: load acceptance, phase counting and STOP abort.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      preg_d  = preg_q;
      lfsr_d  = busy ? lfsr_step : lfsr_q;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            // A load in DONE wins over STOP simply because STOP is not looked at here.
            if (load) begin
               state_d = S_INITS;
               cnt_d   = '0;
               preg_d  = P;
               lfsr_d  = fix_seed(seed_src);
            end
         end
         S_INITS: begin
            if (STOP) begin
               state_d = S_DONE;
            end else if (cnt_q == INIT_LAST) begin
               state_d = S_RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_RUN: begin
            if (STOP || (cnt_q == RUN_LAST)) begin
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State, LFSR, captured probability and cycle counter registers.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_IDLE;
         lfsr_q  <= fix_seed(SEED);
         preg_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         lfsr_q  <= lfsr_d;
         preg_q  <= preg_d;
         cnt_q   <= cnt_d;
      end
   end

   assign SEL  = lfsr_q;
   assign C    = busy && (lfsr_q[PROB_W-1:0] < preg_q);
   assign INIT = (state_q == S_INITS);
   assign BUSY = busy;
   assign DONE = (state_q == S_DONE);

endmodule

// File: tb/tb_stoch_chan_src.sv
// tb/tb_stoch_chan_src.sv - self-checking bench for stoch_chan_src (default build)
module tb_stoch_chan_src;

   logic       clk = 1'b0;
   logic       rst;
   logic       ld_vld;
   logic       ld_rdy;
   logic [7:0] p;
   logic       stop;
   logic       c;
   logic [7:0] sel;
   logic       init;
   logic       busy;
   logic       done;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   stoch_chan_src dut (
      .CLK    (clk),
      .RST    (rst),
      .LD_VLD (ld_vld),
      .LD_RDY (ld_rdy),
      .P      (p),
      .STOP   (stop),
      .C      (c),
      .SEL    (sel),
      .INIT   (init),
      .BUSY   (busy),
      .DONE   (done)
   );

   typedef struct {
      logic [7:0] p;
      int         ones;
   } vec_t;

   vec_t       vecs [6];
   logic [7:0] sel_ref [8];

   function automatic logic [7:0] lfsr8_next(input logic [7:0] x);
      return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge of the first cycle after the load edge.
   task automatic do_load(input logic [7:0] pv, input logic with_stop);
      ld_vld = 1'b1;
      p      = pv;
      stop   = with_stop;
      @(negedge clk);
      ld_vld = 1'b0;
      stop   = 1'b0;
   endtask

   task automatic wait_run(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 64; i++) begin
         if (!init && busy) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   initial begin
      logic [7:0] model;
      logic [7:0] s0;
      int         init_n, run_n, sel_bad, ones, bad_ff;
      bit         ok, done_seen;

      rst = 1'b1; ld_vld = 1'b0; p = 8'h00; stop = 1'b0;
      vecs[0] = '{8'h00, 0};
      vecs[1] = '{8'h01, 0};
      vecs[2] = '{8'h02, 1};
      vecs[3] = '{8'h10, 15};
      vecs[4] = '{8'h80, 127};
      vecs[5] = '{8'hFF, 254};
      sel_ref[0] = 8'h01; sel_ref[1] = 8'h02; sel_ref[2] = 8'h04; sel_ref[3] = 8'h08;
      sel_ref[4] = 8'h11; sel_ref[5] = 8'h23; sel_ref[6] = 8'h47; sel_ref[7] = 8'h8E;

      // reset state
      @(negedge clk); @(negedge clk);
      check("rst_c", c, 0);
      check("rst_init", init, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_ld_rdy", ld_rdy, 1);
      check("rst_sel", sel, 8'h01);
      rst = 1'b0;

      // STOP in IDLE is ignored
      stop = 1'b1; @(negedge clk); stop = 1'b0;
      check("idle_stop_busy", busy, 0);
      check("idle_stop_done", done, 0);

      // full frame, P=80: phase lengths and SEL sequence
      do_load(8'h80, 1'b0);
      model = 8'h01; init_n = 0; run_n = 0; sel_bad = 0;
      for (int i = 0; i < 2000 && !done; i++) begin
         if (i < 8) check($sformatf("sel_init%0d", i), sel, sel_ref[i]);
         if (sel !== model) sel_bad++;
         if (init) init_n++;
         else if (busy) run_n++;
         model = lfsr8_next(model);
         @(negedge clk);
      end
      check("frame_done", done, 1);
      check("frame_ld_rdy", ld_rdy, 1);
      check("frame_init_cycles", init_n, 16);
      check("frame_run_cycles", run_n, 1024);
      check("frame_sel_seq_errors", sel_bad, 0);
      check("frame_done_sel", sel, model);
      check("frame_done_c", c, 0);
      s0 = sel;
      repeat (2) @(negedge clk);
      check("frame_done_sel_hold", sel, s0);

      // probability table: C ones over 255 RUN cycles equals P-1 (0 for P=0)
      for (int v = 0; v < 6; v++) begin
         do_load(vecs[v].p, 1'b0);
         wait_run(ok);
         check("tbl_reach_run", ok, 1);
         ones = 0; bad_ff = 0;
         for (int k = 0; k < 255; k++) begin
            if (c) ones++;
            if ((c == 1'b0) != (sel == 8'hFF)) bad_ff++;
            @(negedge clk);
         end
         check($sformatf("tbl_ones_p%02h", vecs[v].p), ones, vecs[v].ones);
         if (vecs[v].p == 8'hFF) check("tbl_ff_zero_only_at_ff", bad_ff, 0);
         stop = 1'b1; @(negedge clk); stop = 1'b0;
         check("tbl_stop_done", done, 1);
      end

      // STOP on the 5th RUN cycle, then load with STOP held in DONE
      do_load(8'h80, 1'b0);
      wait_run(ok);
      check("stop_reach_run", ok, 1);
      repeat (4) @(negedge clk);
      stop = 1'b1; @(negedge clk); stop = 1'b0;
      check("stop_done", done, 1);
      check("stop_c", c, 0);
      check("stop_busy", busy, 0);
      check("stop_ld_rdy", ld_rdy, 1);
      s0 = sel;
      repeat (3) @(negedge clk);
      check("stop_sel_frozen", sel, s0);
      check("stop_done_held", done, 1);
      do_load(8'h20, 1'b1);
      check("done_load_init", init, 1);
      check("done_load_done", done, 0);
      check("done_load_sel_seed", sel, 8'h01);

      // LD_VLD with P=10 during RUN is ignored
      wait_run(ok);
      check("ign_reach_run", ok, 1);
      ones = 0; run_n = 0;
      for (int k = 0; k < 1100 && busy; k++) begin
         if (k == 0) begin
            ld_vld = 1'b1;
            p      = 8'h10;
         end else begin
            ld_vld = 1'b0;
         end
         if (k < 255 && c) ones++;
         run_n++;
         @(negedge clk);
      end
      ld_vld = 1'b0;
      check("ign_run_cycles", run_n, 1024);
      check("ign_ones_p20", ones, 31);
      check("ign_done", done, 1);

      // asynchronous reset mid-INIT
      do_load(8'h80, 1'b0);
      repeat (4) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("arst_sel", sel, 8'h01);
      check("arst_init", init, 0);
      check("arst_busy", busy, 0);
      check("arst_done", done, 0);
      check("arst_ld_rdy", ld_rdy, 1);
      check("arst_c", c, 0);
      done_seen = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (done) done_seen = 1'b1;
      end
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (done) done_seen = 1'b1;
      end
      check("arst_no_done", done_seen, 0);
      check("arst_idle_busy", busy, 0);
      check("arst_idle_sel", sel, 8'h01);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
